// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: word geometry,
// the frame start marker, the FSM state encoding and a frame-length helper.
package imem_loader_pkg;

    localparam int         WORD_W    = 32;
    localparam int         BYTE_W    = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_ERR
    } state_t;

    // A word count is usable when it is non-zero and fits the memory.
    function automatic logic count_ok(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (int'(n) <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: the loader itself; slave: the stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    import imem_loader_pkg::*;

    logic                in_valid;
    logic [BYTE_W-1:0]   in_data;
    logic                in_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                cpu_hold;
    logic                done;
    logic                err;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer. word_nxt is the current word with the
// incoming byte already inserted, so the loader can register the complete
// word on the same edge that accepts the 4th byte; full flags that edge.
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_nxt,
    output logic              full
);

    logic [1:0]        idx;
    logic [WORD_W-1:0] word_q;

    // Insert the incoming byte into its lane of the held word.
    always_comb begin
        word_nxt                 = word_q;
        word_nxt[8*idx +: 8]     = byte_in;
    end

    assign full = load && (idx == 2'd3);

    // Lane index and partial word; cleared while the finished word is written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx    <= 2'd0;
            word_q <= '0;
        end else if (clear) begin
            idx    <= 2'd0;
            word_q <= '0;
        end else if (load) begin
            idx    <= idx + 2'd1;
            word_q <= word_nxt;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses SYNC, N, 4*N data bytes, CHK frames,
// writes packed words to consecutive word indices and holds the CPU while
// a frame is in flight.
//
//  state | meaning
//  IDLE  | waiting for SYNC, other bytes dropped
//  COUNT | taking the word count N
//  DATA  | collecting bytes of the current word
//  WRITE | one-cycle memory write, input stalled
//  CHECK | taking and comparing the checksum byte
//  ERR   | one-cycle error exit, input stalled
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter logic [7:0] SYNC_CODE = SYNC_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    imem_loader_if.master bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int WL_W  = ADDR_W + 1;

    state_t            state;
    logic [WL_W-1:0]   words_left;
    logic [BYTE_W-1:0] chk;

    logic              accept;
    logic              pk_load;
    logic              pk_clear;
    logic              pk_full;
    logic [WORD_W-1:0] pk_word_nxt;

    assign accept   = bus.in_valid && bus.in_ready;
    assign pk_load  = accept && (state == ST_DATA);
    assign pk_clear = (state == ST_WRITE) || (state == ST_IDLE);

    imem_loader_word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (pk_clear),
        .load     (pk_load),
        .byte_in  (bus.in_data),
        .word_nxt (pk_word_nxt),
        .full     (pk_full)
    );

    // Frame FSM; every output is registered, in_ready is set for the state
    // being entered so it is already correct in that state's first cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            words_left    <= '0;
            chk           <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_hold  <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            bus.done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (accept && bus.in_data == SYNC_CODE) begin
                        state        <= ST_COUNT;
                        bus.cpu_hold <= 1'b1;
                        bus.err      <= 1'b0;
                        bus.mem_addr <= '0;
                        chk          <= '0;
                    end
                end
                ST_COUNT: begin
                    if (accept) begin
                        if (count_ok(bus.in_data, DEPTH)) begin
                            words_left <= WL_W'(bus.in_data);
                            state      <= ST_DATA;
                        end else begin
                            bus.in_ready <= 1'b0;
                            state        <= ST_ERR;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        chk <= chk ^ bus.in_data;
                        if (pk_full) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= pk_word_nxt;
                            bus.in_ready  <= 1'b0;
                            state         <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // Address wraps to 0 after a full-depth image; harmless,
                    // the frame moves on to CHECK.
                    bus.mem_addr <= bus.mem_addr + 1'b1;
                    words_left   <= words_left - 1'b1;
                    bus.in_ready <= 1'b1;
                    if (words_left == WL_W'(1))
                        state <= ST_CHECK;
                    else
                        state <= ST_DATA;
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (bus.in_data == chk) begin
                            bus.done     <= 1'b1;
                            bus.cpu_hold <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            bus.in_ready <= 1'b0;
                            state        <= ST_ERR;
                        end
                    end
                end
                ST_ERR: begin
                    bus.err      <= 1'b1;
                    bus.cpu_hold <= 1'b0;
                    bus.in_ready <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    bus.in_ready <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, good/bad frames, count limits,
// stream gaps, full-depth image and reset mid-frame.
module tb_imem_loader;

    logic clk;
    logic reset;

    imem_loader_if #(.ADDR_W(6)) bus ();

    imem_loader #(.ADDR_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int timeouts = 0;

    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_cnt  = 0;
    logic        rdy_on    = 1'b0;
    int          rdy_viol  = 0;

    logic [7:0]  frame[$];
    logic [31:0] exp_words[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observe the write port, done pulses and the in_ready/WRITE relation.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
        end
        if (bus.done === 1'b1) done_cnt++;
        if (rdy_on && (bus.in_ready !== ~bus.mem_we)) rdy_viol++;
    end

    task automatic clear_log();
        wr_addr  = {};
        wr_data  = {};
        done_cnt = 0;
        rdy_viol = 0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns on the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            timeouts++;
            $display("FAIL send_timeout byte=%h", b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        foreach (frame[i])
            send_byte(frame[i], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
    endtask

    task automatic make_frame(input int n, input logic [7:0] base);
        logic [7:0]  b;
        logic [7:0]  c;
        logic [31:0] w;
        frame     = {};
        exp_words = {};
        c = 8'h00;
        frame.push_back(8'hA5);
        frame.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                b = 8'(base + 8'(4*i + k));
                w[8*k +: 8] = b;
                frame.push_back(b);
                c = c ^ b;
            end
            exp_words.push_back(w);
        end
        frame.push_back(c);
    endtask

    // Two-word program; XOR of the eight data bytes is 0x95.
    task automatic make_small(input logic [7:0] chk_byte);
        frame     = '{8'hA5, 8'h02, 8'h13, 8'h05, 8'h00, 8'h00,
                      8'h93, 8'h00, 8'h10, 8'h00, chk_byte};
        exp_words = '{32'h0000_0513, 32'h0010_0093};
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_wr_cnt"}, 32'(wr_addr.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < wr_addr.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
            check_eq($sformatf("%s_data%0d", tag, i), wr_data[i], exp_words[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check_eq({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check_eq({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        check_eq({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        check_eq({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'd0);
        check_eq({tag, "_done"},      32'(bus.done),      32'd0);
        check_eq({tag, "_err"},       32'(bus.err),       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with a SYNC byte presented
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rel_cpu_hold", 32'(bus.cpu_hold), 32'd0);

        // 2: good two-word frame
        clear_log();
        rdy_on = 1'b1;
        make_small(8'h95);
        send_byte(frame[0], 0);
        check_eq("s2_hold_on", 32'(bus.cpu_hold), 32'd1);
        for (int i = 1; i < 6; i++) send_byte(frame[i], 0);
        check_eq("s2_we_latency", 32'(bus.mem_we), 32'd1);
        check_eq("s2_rdy_in_write", 32'(bus.in_ready), 32'd0);
        for (int i = 6; i < 11; i++) send_byte(frame[i], 0);
        check_eq("s2_done_pulse", 32'(bus.done), 32'd1);
        check_eq("s2_hold_off", 32'(bus.cpu_hold), 32'd0);
        @(negedge clk);
        check_eq("s2_done_one_cycle", 32'(bus.done), 32'd0);
        rdy_on = 1'b0;
        check_writes("s2");
        check_eq("s2_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("s2_err", 32'(bus.err), 32'd0);
        check_eq("s2_rdy_viol", 32'(rdy_viol), 32'd0);

        // 3: bad checksum -> writes kept, sticky err
        clear_log();
        make_small(8'h00);
        send_frame(0);
        repeat (4) @(negedge clk);
        check_writes("s3");
        check_eq("s3_done_cnt", 32'(done_cnt), 32'd0);
        check_eq("s3_err", 32'(bus.err), 32'd1);
        check_eq("s3_hold", 32'(bus.cpu_hold), 32'd0);
        send_byte(8'h11, 0);
        check_eq("s3_err_sticky", 32'(bus.err), 32'd1);
        send_byte(8'hA5, 0);
        check_eq("s3_err_clr", 32'(bus.err), 32'd0);

        // 4: N=0 (continuing the frame opened above) and N=65
        clear_log();
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        check_eq("s4_n0_err", 32'(bus.err), 32'd1);
        check_eq("s4_n0_hold", 32'(bus.cpu_hold), 32'd0);
        send_byte(8'hA5, 0);
        send_byte(8'h41, 0);
        repeat (2) @(negedge clk);
        check_eq("s4_n65_err", 32'(bus.err), 32'd1);
        check_eq("s4_no_writes", 32'(wr_addr.size()), 32'd0);

        // 5: garbage before SYNC, random stream gaps
        clear_log();
        rdy_on = 1'b1;
        send_byte(8'h11, 1);
        send_byte(8'h22, 2);
        check_eq("s5_garbage_hold", 32'(bus.cpu_hold), 32'd0);
        make_small(8'h95);
        send_frame(3);
        repeat (3) @(negedge clk);
        rdy_on = 1'b0;
        check_writes("s5");
        check_eq("s5_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("s5_err", 32'(bus.err), 32'd0);
        check_eq("s5_rdy_viol", 32'(rdy_viol), 32'd0);

        // 6: full-depth image
        clear_log();
        rdy_on = 1'b1;
        make_frame(64, 8'h3C);
        send_frame(0);
        repeat (2) @(negedge clk);
        rdy_on = 1'b0;
        check_writes("s6");
        check_eq("s6_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("s6_err", 32'(bus.err), 32'd0);
        check_eq("s6_rdy_viol", 32'(rdy_viol), 32'd0);

        // 6b: reset after the 3rd word of a 64-word frame
        clear_log();
        make_frame(64, 8'h07);
        for (int i = 0; i < 2 + 12; i++) send_byte(frame[i], 0);
        check_eq("s6b_we_3rd", 32'(bus.mem_we), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("s6b_rst");
        check_eq("s6b_wr_cnt", 32'(wr_addr.size()), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check_eq("s6b_rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Back in IDLE: a fresh frame loads normally
        clear_log();
        make_small(8'h95);
        send_frame(0);
        repeat (2) @(negedge clk);
        check_writes("s6c");
        check_eq("s6c_done_cnt", 32'(done_cnt), 32'd1);

        check_eq("no_timeouts", 32'(timeouts), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
